comparator_accumulator: RTL and testbench

COMPARATOR_ACCUMULATOR -- requirements
Module: comparator_accumulator

---
 rtl/comparator_accumulator_pkg.sv | 16 +
 rtl/comparator_accumulator_cell.sv | 34 +++
 rtl/comparator_accumulator.sv | 104 ++++++++++
 tb/tb_comparator_accumulator.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_accumulator_pkg.sv
// Shared helpers for the comparator accumulator: reduction mode constants and counter sizing.
`default_nettype none

package comparator_accumulator_pkg;

    localparam int MODE_MAX = 1;
    localparam int MODE_MIN = 0;

    // A one-beat block still needs a 1-bit counter so the port and compare widths stay legal.
    function automatic int unsigned count_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_accumulator_cell.sv
// Combinational two-operand max/min select; ties return the left operand.
`default_nettype none

module comparator_cell
    import comparator_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX1_MIN0  = MODE_MAX,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH-1:0] left,
    input  logic [DATA_WIDTH-1:0] right,
    output logic [DATA_WIDTH-1:0] result
);

    logic right_wins;

    generate
        if (SIGNED != 0 && MAX1_MIN0 != 0) begin : g_smax
            assign right_wins = $signed(right) > $signed(left);
        end else if (SIGNED != 0) begin : g_smin
            assign right_wins = $signed(right) < $signed(left);
        end else if (MAX1_MIN0 != 0) begin : g_umax
            assign right_wins = right > left;
        end else begin : g_umin
            assign right_wins = right < left;
        end
    endgenerate

    assign result = right_wins ? right : left;

endmodule

`default_nettype wire

// File: rtl/comparator_accumulator.sv
// Temporal max/min reduction of DEPTH input beats into one registered output with valid/ready handshakes.
`default_nettype none

module comparator_accumulator
    import comparator_accumulator_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX1_MIN0  = MODE_MAX,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned     CNT_W    = count_width(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0]   cmp_result;
    logic                    last_beat;
    logic                    in_xfer;
    logic                    out_xfer;

    comparator_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX1_MIN0  (MAX1_MIN0),
        .SIGNED     (SIGNED)
    ) u_cell (
        .left   (acc_q),
        .right  (in_data),
        .result (cmp_result)
    );

    // Only the final beat can stall, and only if the pending result is not leaving this cycle.
    assign last_beat = (count_q == LAST_CNT);
    assign in_ready  = !(last_beat && out_valid_q && !out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            if (last_beat) begin
                out_data_d  = (DEPTH == 1) ? in_data : cmp_result;
                out_valid_d = 1'b1;
                count_d     = '0;
                acc_d       = '0;
                state_d     = IDLE;
            end else begin
                acc_d   = (state_q == IDLE) ? in_data : cmp_result;
                count_d = count_q + CNT_W'(1);
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator_accumulator.sv
// Self-checking bench: four configurations share one stimulus stream; directed scenarios plus a randomized model run.
`default_nettype none

module tb_comparator_accumulator;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     out_valid;
    logic [7:0]       out_data [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: D=4 unsigned max, 1: D=4 signed min, 2: D=3 unsigned max, 3: D=1 unsigned max
    comparator_accumulator #(.DEPTH(4), .DATA_WIDTH(8), .MAX1_MIN0(1), .SIGNED(0)) u_umax4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready));
    comparator_accumulator #(.DEPTH(4), .DATA_WIDTH(8), .MAX1_MIN0(0), .SIGNED(1)) u_smin4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready));
    comparator_accumulator #(.DEPTH(3), .DATA_WIDTH(8), .MAX1_MIN0(1), .SIGNED(0)) u_umax3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready));
    comparator_accumulator #(.DEPTH(1), .DATA_WIDTH(8), .MAX1_MIN0(1), .SIGNED(0)) u_umax1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[3]),
        .out_data(out_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready));

    always #5 clk = ~clk;

    function automatic int dep_of(int k);
        case (k)
            0: return 4;
            1: return 4;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_max(int k);
        return k != 1;
    endfunction

    function automatic int val_of(int k, logic [7:0] x);
        if (k == 1) return int'($signed(x));
        return int'({24'd0, x});
    endfunction

    // Transaction-level model: blocks collected in queues, reduced on completion.
    bit         m_valid [N];
    logic [7:0] m_data  [N];
    logic [7:0] m_blk   [N][$];

    function automatic logic [7:0] reduce_blk(int k);
        logic [7:0] best;
        best = m_blk[k][0];
        foreach (m_blk[k][i]) begin
            if (is_max(k) ? (val_of(k, m_blk[k][i]) > val_of(k, best))
                          : (val_of(k, m_blk[k][i]) < val_of(k, best)))
                best = m_blk[k][i];
        end
        return best;
    endfunction

    function automatic bit exp_ready(int k);
        return !((m_blk[k].size() == dep_of(k) - 1) && m_valid[k] && !out_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 8'h00;
            m_blk[k].delete();
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            bit acc;
            acc = in_valid && exp_ready(k);
            if (m_valid[k] && out_ready) m_valid[k] = 1'b0;
            if (acc) begin
                m_blk[k].push_back(in_data);
                if (m_blk[k].size() == dep_of(k)) begin
                    m_data[k]  = reduce_blk(k);
                    m_valid[k] = 1'b1;
                    m_blk[k].delete();
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            n_checks += 3;
            if (out_valid[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid dut%0d: got %b want 0", k, out_valid[k]);
            end
            if (out_data[k] !== 8'h00) begin
                n_fail++; $display("FAIL reset_out_data dut%0d: got %h want 00", k, out_data[k]);
            end
            if (in_ready[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready dut%0d: got %b want 1", k, in_ready[k]);
            end
        end
    endtask

    task automatic test_max_basic();
        logic [7:0] b [4];
        b[0] = 8'd3; b[1] = 8'd9; b[2] = 8'd2; b[3] = 8'd7;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = b[i];
            #1;
            n_checks++;
            if (in_ready[0] !== 1'b1) begin
                n_fail++; $display("FAIL max_basic_ready beat%0d: got %b want 1", i, in_ready[0]);
            end
            n_checks++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL max_basic_early_valid beat%0d: got %b want 0", i, out_valid[0]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks += 3;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'd9) begin
            n_fail++; $display("FAIL max_basic_result: got v=%b d=%0d want v=1 d=9", out_valid[0], out_data[0]);
        end
        if (out_data[1] !== 8'd2) begin
            n_fail++; $display("FAIL smin_unsigned_range_result: got %0d want 2", out_data[1]);
        end
        if (out_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL smin_valid: got %b want 1", out_valid[1]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL max_basic_drain: got %b want 0", out_valid[0]);
        end
    endtask

    task automatic test_signed_min();
        logic [7:0] b [4];
        b[0] = 8'h05; b[1] = 8'hFE; b[2] = 8'h80; b[3] = 8'h7F;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks += 2;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h80) begin
            n_fail++; $display("FAIL signed_min: got v=%b d=%h want v=1 d=80", out_valid[1], out_data[1]);
        end
        if (out_data[0] !== 8'hFE) begin
            n_fail++; $display("FAIL unsigned_max_same_beats: got %h want fe", out_data[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            @(negedge clk);
        end
        n_checks++;
        if (out_valid[2] !== 1'b1 || out_data[2] !== 8'd3) begin
            n_fail++; $display("FAIL bp_first_result: got v=%b d=%0d want v=1 d=3", out_valid[2], out_data[2]);
        end
        for (int i = 4; i <= 5; i++) begin
            in_data = 8'(i);
            #1;
            n_checks++;
            if (in_ready[2] !== 1'b1) begin
                n_fail++; $display("FAIL bp_nonfinal_ready beat%0d: got %b want 1", i, in_ready[2]);
            end
            @(negedge clk);
        end
        in_data = 8'd6;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks += 2;
            if (in_ready[2] !== 1'b0) begin
                n_fail++; $display("FAIL bp_final_stall cyc%0d: got %b want 0", c, in_ready[2]);
            end
            if (out_valid[2] !== 1'b1 || out_data[2] !== 8'd3) begin
                n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b d=%0d want v=1 d=3", c, out_valid[2], out_data[2]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready[2] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready[2]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[2] !== 1'b1 || out_data[2] !== 8'd6) begin
            n_fail++; $display("FAIL bp_second_result: got v=%b d=%0d want v=1 d=6", out_valid[2], out_data[2]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[2] !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [20];
        int pulses;
        pulses = 0;
        foreach (b[i]) b[i] = 8'($urandom);
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            bit want_v;
            if (k < 20) in_data = b[k];
            else        in_valid = 1'b0;
            #1;
            if (k < 20) begin
                n_checks++;
                if (in_ready[0] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_ready beat%0d: got %b want 1", k, in_ready[0]);
                end
            end
            want_v = (k > 0) && ((k - 1) % 4 == 3);
            n_checks++;
            if (out_valid[0] !== want_v) begin
                n_fail++; $display("FAIL b2b_valid cyc%0d: got %b want %b", k, out_valid[0], want_v);
            end
            if (want_v) begin
                logic [7:0] best;
                pulses++;
                best = 8'h00;
                for (int j = k - 4; j < k; j++) if (b[j] > best) best = b[j];
                n_checks++;
                if (out_data[0] !== best) begin
                    n_fail++; $display("FAIL b2b_data cyc%0d: got %h want %h", k, out_data[0], best);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 5) begin
            n_fail++; $display("FAIL b2b_count: got %0d results want 5", pulses);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [7:0] b [4];
        b[0] = 8'd1; b[1] = 8'd2; b[2] = 8'd3; b[3] = 8'd4;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'd10; @(negedge clk);
        in_data = 8'd20; @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = b[i];
            #1;
            n_checks++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_output beat%0d: got %b want 0", i, out_valid[0]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'd4) begin
            n_fail++; $display("FAIL abort_result: got v=%b d=%0d want v=1 d=4", out_valid[0], out_data[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00) begin
            n_fail++; $display("FAIL reset_drops_pending: got v=%b d=%0d want v=0 d=0", out_valid[0], out_data[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_depth1();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'hAA;
        #1;
        n_checks++;
        if (in_ready[3] !== 1'b1) begin
            n_fail++; $display("FAIL d1_ready: got %b want 1", in_ready[3]);
        end
        @(negedge clk);
        in_data = 8'h55;
        n_checks++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== 8'hAA) begin
            n_fail++; $display("FAIL d1_first: got v=%b d=%h want v=1 d=aa", out_valid[3], out_data[3]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== 8'h55) begin
            n_fail++; $display("FAIL d1_second: got v=%b d=%h want v=1 d=55", out_valid[3], out_data[3]);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[3] !== 1'b0) begin
            n_fail++; $display("FAIL d1_drain: got %b want 0", out_valid[3]);
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            bit do_rst;
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (out_valid[k] !== m_valid[k]) begin
                    n_fail++; $display("FAIL rand_valid dut%0d cyc%0d: got %b want %b", k, c, out_valid[k], m_valid[k]);
                end
                if (m_valid[k]) begin
                    n_checks++;
                    if (out_data[k] !== m_data[k]) begin
                        n_fail++; $display("FAIL rand_data dut%0d cyc%0d: got %h want %h", k, c, out_data[k], m_data[k]);
                    end
                end
            end
            do_rst    = ($urandom_range(0, 99) < 2);
            rst       = do_rst;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (do_rst) begin
                model_reset();
            end else begin
                for (int k = 0; k < N; k++) begin
                    n_checks++;
                    if (in_ready[k] !== exp_ready(k)) begin
                        n_fail++; $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", k, c, in_ready[k], exp_ready(k));
                    end
                end
                model_step();
            end
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_signed_min();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_depth1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
